// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter/sequencer for the single data-BRAM port.
// Port 0 is the core load/store stage, port 1 the program/data loader.
// Accesses are serialised; loads wait out READ_LATENCY before completing.

`ifndef LEN_MEM_ADDR
`define LEN_MEM_ADDR 32
`endif
`ifndef LEN_WORD
`define LEN_WORD 32
`endif
`ifndef LEN_MEMDATA_ADDR
`define LEN_MEMDATA_ADDR 14
`endif

module mem_arbiter #(
  parameter int unsigned READ_LATENCY = 2,  // legal 1..7
  parameter int unsigned ROUND_ROBIN  = 1   // 1 = alternate priority, 0 = port 0 fixed priority
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         req0,
  input  logic                         req1,
  input  logic                         we0,
  input  logic                         we1,
  input  logic [`LEN_MEM_ADDR-1:0]     addr0,
  input  logic [`LEN_MEM_ADDR-1:0]     addr1,
  input  logic [`LEN_WORD-1:0]         wdata0,
  input  logic [`LEN_WORD-1:0]         wdata1,
  output logic                         accepted0,
  output logic                         accepted1,
  output logic                         accessed0,
  output logic                         accessed1,
  output logic [`LEN_WORD-1:0]         rdata0,
  output logic [`LEN_WORD-1:0]         rdata1,
  output logic                         busy,
  output logic [`LEN_MEMDATA_ADDR-1:0] a_mem,
  output logic [`LEN_WORD-1:0]         sd_mem,
  input  logic [`LEN_WORD-1:0]         ld_mem,
  output logic                         mem_write_flag
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ_WAIT
  } state_e;

  localparam logic [2:0] RL_INIT = 3'(READ_LATENCY);

  state_e                        state_q, state_d;
  logic                          owner_q, owner_d;
  logic                          rr_ptr_q, rr_ptr_d;
  logic [2:0]                    cnt_q, cnt_d;
  logic [`LEN_MEMDATA_ADDR-1:0]  a_mem_q, a_mem_d;
  logic [`LEN_WORD-1:0]          sd_mem_q, sd_mem_d;
  logic [`LEN_WORD-1:0]          rdata0_q, rdata0_d;
  logic [`LEN_WORD-1:0]          rdata1_q, rdata1_d;
  logic                          wflag_q, wflag_d;
  logic                          accessed0_q, accessed0_d;
  logic                          accessed1_q, accessed1_d;

  logic                          grant0, grant1;
  logic                          gnt_valid, gnt_port, gnt_we;
  logic [`LEN_MEMDATA_ADDR-1:0]  gnt_word;
  logic [`LEN_WORD-1:0]          gnt_wdata;

  // Byte-offset and out-of-range address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr0[`LEN_MEM_ADDR-1:`LEN_MEMDATA_ADDR+2], addr0[1:0],
                              addr1[`LEN_MEM_ADDR-1:`LEN_MEMDATA_ADDR+2], addr1[1:0]};

  // State register and datapath flops, asynchronously cleared
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      rr_ptr_q    <= 1'b0;
      cnt_q       <= '0;
      a_mem_q     <= '0;
      sd_mem_q    <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      wflag_q     <= 1'b0;
      accessed0_q <= 1'b0;
      accessed1_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      a_mem_q     <= a_mem_d;
      sd_mem_q    <= sd_mem_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      wflag_q     <= wflag_d;
      accessed0_q <= accessed0_d;
      accessed1_q <= accessed1_d;
    end
  end

  // Arbitration: only in IDLE; pointer port wins a tie when round-robin is on
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (req0 && req1) begin
        if ((ROUND_ROBIN != 0) && rr_ptr_q) grant1 = 1'b1;
        else                                grant0 = 1'b1;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
    gnt_valid = grant0 | grant1;
    gnt_port  = grant1;
    gnt_we    = grant1 ? we1 : we0;
    gnt_word  = grant1 ? addr1[`LEN_MEMDATA_ADDR+1:2] : addr0[`LEN_MEMDATA_ADDR+1:2];
    gnt_wdata = grant1 ? wdata1 : wdata0;
  end

  // Next-state and datapath: accessed pulses are registered so a store
  // completes in its WRITE cycle and a load in the IDLE cycle after capture
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    a_mem_d     = a_mem_q;
    sd_mem_d    = sd_mem_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    wflag_d     = 1'b0;
    accessed0_d = 1'b0;
    accessed1_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d  = gnt_port;
          rr_ptr_d = ~gnt_port;
          a_mem_d  = gnt_word;
          sd_mem_d = gnt_wdata;
          wflag_d  = gnt_we;
          if (gnt_we) begin
            state_d     = WRITE;
            accessed0_d = ~gnt_port;
            accessed1_d = gnt_port;
          end else begin
            state_d = READ_WAIT;
            cnt_d   = RL_INIT;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      READ_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d     = IDLE;
          accessed0_d = ~owner_q;
          accessed1_d = owner_q;
          if (owner_q) rdata1_d = ld_mem;
          else         rdata0_d = ld_mem;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: grant pulses are combinational and suppressed while in reset
  always_comb begin
    accepted0      = rstn & grant0;
    accepted1      = rstn & grant1;
    accessed0      = accessed0_q;
    accessed1      = accessed1_q;
    rdata0         = rdata0_q;
    rdata1         = rdata1_q;
    busy           = (state_q != IDLE);
    a_mem          = a_mem_q;
    sd_mem         = sd_mem_q;
    mem_write_flag = wflag_q;
  end

endmodule
